bp_clint_slice: RTL and testbench
=================================

Name: bp_clint_slice

Overview:
- Per-core memory-mapped CLINT device. It sits directly downstream of the platform address map and decodes the mipi, mtimecmp and mtime regions (0x0200_0xxx, 0x0200_4xxx, 0x0200_bff8).
- It accepts one uncached load/store at a time from the device-side request channel and returns a response.
- It maintains a free-running mtime counter.
- It drives machine software and timer interrupt lines to the core.

Parameters:
- paddr_width_p, 56, physical address width of request.
- data_width_p, 64, request/response data width; fixed at 64.
- timer_div_p, 1, core clocks per mtime increment; legal range 1..255.

Ports:
- clk_i  in  1  core clock
- reset_n_i  in  1  synchronous active-low reset
- req_v_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_addr_i  in  paddr_width_p  physical byte address
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  0/1 = illegal; 2 = 4 bytes; 3 = 8 bytes
- req_data_i  in  64  store data, right-justified
- resp_v_o  out  1  response valid
- resp_yumi_i  in  1  response consumed
- resp_data_o  out  64  load data, right-justified; 0 for stores
- resp_err_o  out  1  unmapped address or illegal size
- software_irq_o  out  1  mipi[0]
- timer_irq_o  out  1  mtime >= mtimecmp, registered

Behaviour:
- Reset (reset_n_i == 0 at a clock edge) forces the following, regardless of any in-flight transaction:
  - FSM = READY; req_ready_o = 1; resp_v_o = 0; resp_data_o = 0; resp_err_o = 0.
  - mipi = 0; mtime = 0; mtimecmp = all-ones; prescaler = 0.
  - software_irq_o = 0; timer_irq_o = 0.
- FSM has two states:
  - READY: req_ready_o = 1. On req_v_i & req_ready_o, perform the access in this same cycle, latch response data/err, and go to RESP.
  - RESP: req_ready_o = 0; resp_v_o = 1; resp_data_o/resp_err_o held stable. On resp_yumi_i, go to READY.
  - Load-to-response latency is 1 cycle. Maximum throughput is one request per 2 cycles.
- Address decode (bits above 31 must be zero, otherwise error):
  - addr[31:12] == 0x02000 → mipi. Offset 0 only; other offsets read 0 with no error.
  - addr[31:12] == 0x02004 → mtimecmp. Offset 0/4 only.
  - addr[31:0] == 0x0200_bff8 or 0x0200_bffc → mtime.
  - Anything else: resp_err_o = 1, read data 0, no state change.
- Size and alignment:
  - size 3 requires addr[2:0] == 0.
  - size 2 requires addr[1:0] == 0; addr[2] selects the upper (1) or lower (0) 32-bit half.
  - Misalignment or size < 2: resp_err_o = 1, no state change.
- Load data:
  - A 4-byte read returns the selected half zero-extended into resp_data_o[31:0].
  - mipi reads return {63'b0, mipi}.
- Store effects:
  - A 4-byte store updates only the selected half.
  - A mipi store writes only data[0].
- mtime counting:
  - The prescaler increments every cycle.
  - When the prescaler == timer_div_p-1, it wraps to 0 and mtime += 1, modulo 2^64; 0xFFFF_FFFF_FFFF_FFFF → 0.
  - A store to mtime in the same cycle as a tick: the store wins for the written half; the unwritten half takes its incremented value. The prescaler is not reset by mtime stores.
- Interrupts:
  - timer_irq_o <= (mtime_next >= mtimecmp_next), unsigned 64-bit, evaluated on post-update values. It is therefore valid one cycle after any mtime/mtimecmp change.
  - software_irq_o = mipi register, directly.
- resp_yumi_i asserted while in READY is ignored.

Test Plan:
1. Reset with timer_div_p = 1, run 10 cycles, load 8 B at 0x0200_bff8 → resp_data_o within 9..11, resp_err_o = 0, timer_irq_o = 0.
2. Store 8 B mtimecmp = 20 at 0x0200_4000, keep idle → timer_irq_o rises the cycle after mtime reaches 20. Then store mtimecmp = all-ones → timer_irq_o falls 1 cycle after the store is accepted.
3. Store 4 B 0x1 at 0x0200_0000 → software_irq_o = 1 the next cycle. Load → data 0x1. Store 0x0 → software_irq_o = 0.
4. Store 8 B mtime = 0xFFFF_FFFF_FFFF_FFFE with timer_div_p = 1 → two cycles later mtime = 0, no error. A 4 B store of 0xDEAD_BEEF at 0x0200_bffc sets only the upper half.
5. Load at 0x0300_0000, then 8 B at 0x0200_4004, then size 1 at 0x0200_0000 → all return resp_err_o = 1, data 0, no register change.
6. Hold resp_yumi_i = 0 for 5 cycles after a load → resp_v_o stays 1, data stable, req_ready_o = 0. Assert reset_n_i = 0 mid-RESP → next cycle resp_v_o = 0 and req_ready_o = 1.

Source files
------------

// File: rtl/bp_clint_slice.sv
// Per-core CLINT slice: mipi / mtimecmp / mtime registers behind a single
// outstanding-request device port, plus the machine software/timer interrupts.
module bp_clint_slice #(
  parameter int paddr_width_p = 56,
  parameter int data_width_p  = 64,
  parameter int timer_div_p   = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic [paddr_width_p-1:0] req_addr_i,
  input  logic                     req_we_i,
  input  logic [1:0]               req_size_i,
  input  logic [data_width_p-1:0]  req_data_i,

  output logic                     resp_v_o,
  input  logic                     resp_yumi_i,
  output logic [data_width_p-1:0]  resp_data_o,
  output logic                     resp_err_o,

  output logic                     software_irq_o,
  output logic                     timer_irq_o
);

  typedef enum logic {READY = 1'b0, RESP = 1'b1} state_e;

  localparam logic [28:0] mtime_dword_lp = 29'(32'h0200_bff8 >> 3);
  localparam logic [7:0]  tick_at_lp     = 8'(timer_div_p - 1);

  state_e      state_q, state_next;
  logic        mipi_q, mipi_next;
  logic [63:0] mtime_q, mtime_next, mtime_inc;
  logic [63:0] mtimecmp_q, mtimecmp_next;
  logic [7:0]  prescaler_q, prescaler_next;
  logic        timer_irq_q;
  logic [63:0] resp_data_q, resp_data_next;
  logic        resp_err_q, resp_err_next;

  logic [31:0] lo;
  logic        high_ok, size_ok, sel_mipi, sel_cmp, sel_time, mipi_off0;
  logic        fire, req_err, wr_en, tick;
  logic [63:0] reg_val, rd_data, wr_mask, wr_data;

  assign lo      = req_addr_i[31:0];
  assign high_ok = ((req_addr_i >> 32) == '0);

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    size_ok   = ((req_size_i == 2'd3) && (lo[2:0] == 3'd0)) ||
                ((req_size_i == 2'd2) && (lo[1:0] == 2'd0));
    sel_mipi  = (lo[31:12] == 20'h02000);
    sel_cmp   = (lo[31:12] == 20'h02004) && (lo[11:3] == 9'd0);
    sel_time  = (lo[31:3] == mtime_dword_lp);
    mipi_off0 = (lo[11:0] == 12'd0);
    req_err   = !(high_ok && size_ok && (sel_mipi || sel_cmp || sel_time));
    fire      = req_v_i && (state_q == READY);
    wr_en     = fire && req_we_i && !req_err;

    reg_val = mtime_q;
    if (sel_mipi)     reg_val = {63'd0, mipi_q & mipi_off0};
    else if (sel_cmp) reg_val = mtimecmp_q;

    // 4-byte reads return the addressed half zero-extended
    if (req_size_i == 2'd3) rd_data = reg_val;
    else if (lo[2])         rd_data = {32'd0, reg_val[63:32]};
    else                    rd_data = {32'd0, reg_val[31:0]};
    if (req_err || req_we_i) rd_data = '0;

    if (req_size_i == 2'd3) wr_mask = '1;
    else if (lo[2])         wr_mask = {32'hffff_ffff, 32'd0};
    else                    wr_mask = {32'd0, 32'hffff_ffff};
    wr_data = (req_size_i == 2'd3) ? req_data_i : {2{req_data_i[31:0]}};

    tick           = (prescaler_q == tick_at_lp);
    prescaler_next = tick ? 8'd0 : prescaler_q + 8'd1;
    mtime_inc      = mtime_q + 64'(tick);

    // a store overrides only the half it writes; the other half keeps its tick
    mtime_next = mtime_inc;
    if (wr_en && sel_time) mtime_next = (mtime_inc & ~wr_mask) | (wr_data & wr_mask);
    mtimecmp_next = mtimecmp_q;
    if (wr_en && sel_cmp) mtimecmp_next = (mtimecmp_q & ~wr_mask) | (wr_data & wr_mask);
    mipi_next = mipi_q;
    if (wr_en && sel_mipi && mipi_off0) mipi_next = req_data_i[0];

    state_next     = state_q;
    resp_data_next = resp_data_q;
    resp_err_next  = resp_err_q;
    case (state_q)
      READY: if (fire) begin
        state_next     = RESP;
        resp_data_next = rd_data;
        resp_err_next  = req_err;
      end
      RESP: if (resp_yumi_i) state_next = READY;
      default: state_next = READY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= READY;
      mipi_q      <= 1'b0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      prescaler_q <= '0;
      timer_irq_q <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_next;
      mipi_q      <= mipi_next;
      mtime_q     <= mtime_next;
      mtimecmp_q  <= mtimecmp_next;
      prescaler_q <= prescaler_next;
      timer_irq_q <= (mtime_next >= mtimecmp_next);
      resp_data_q <= resp_data_next;
      resp_err_q  <= resp_err_next;
    end
  end

  assign req_ready_o    = (state_q == READY);
  assign resp_v_o       = (state_q == RESP);
  assign resp_data_o    = resp_data_q;
  assign resp_err_o     = resp_err_q;
  assign software_irq_o = mipi_q;
  assign timer_irq_o    = timer_irq_q;

endmodule

// File: tb/tb_bp_clint_slice.sv
// Directed bench for bp_clint_slice: register access, mtime/mtimecmp timing,
// decode errors, response back-pressure and reset during a response.
module tb_bp_clint_slice;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_v, req_ready, req_we;
  logic [55:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_data;
  logic        resp_v, resp_yumi, resp_err;
  logic [63:0] resp_data;
  logic        sw_irq, tm_irq;

  int n_checks = 0;
  int n_errors = 0;

  bp_clint_slice #(.paddr_width_p(56), .data_width_p(64), .timer_div_p(1)) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .req_v_i        (req_v),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_data_i     (req_data),
    .resp_v_o       (resp_v),
    .resp_yumi_i    (resp_yumi),
    .resp_data_o    (resp_data),
    .resp_err_o     (resp_err),
    .software_irq_o (sw_irq),
    .timer_irq_o    (tm_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; called and returns 1 time unit after a rising edge.
  task automatic access(input logic we, input logic [55:0] addr, input logic [1:0] size,
                        input logic [63:0] data, output logic [63:0] rdata,
                        output logic err, output logic irq, output logic sw);
    int n;
    req_v = 1'b1; req_we = we; req_addr = addr; req_size = size; req_data = data;
    tick();
    req_v = 1'b0;
    n = 0;
    while (!resp_v && n < 4) begin
      tick();
      n++;
    end
    check("resp_valid_timeout", {63'd0, resp_v}, 64'd1);
    rdata = resp_data; err = resp_err; irq = tm_irq; sw = sw_irq;
    resp_yumi = 1'b1;
    tick();
    resp_yumi = 1'b0;
  endtask

  logic [63:0] rd, held;
  logic        er, ir, sw;

  initial begin
    reset_n = 1'b0; req_v = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'd3;
    req_data = '0; resp_yumi = 1'b0;
    repeat (3) tick();
    check("rst_ready",   {63'd0, req_ready}, 64'd1);
    check("rst_resp_v",  {63'd0, resp_v},    64'd0);
    check("rst_data",    resp_data,          64'd0);
    check("rst_sw_irq",  {63'd0, sw_irq},    64'd0);
    check("rst_tm_irq",  {63'd0, tm_irq},    64'd0);
    reset_n = 1'b1;

    // 1: mtime counts one per cycle after reset
    repeat (10) tick();
    access(1'b0, 56'h0200_bff8, 2'd3, '0, rd, er, ir, sw);
    check("t1_mtime_9_to_11", {63'd0, (rd >= 64'd9 && rd <= 64'd11)}, 64'd1);
    check("t1_err",    {63'd0, er}, 64'd0);
    check("t1_tm_irq", {63'd0, ir}, 64'd0);

    // 2: timer interrupt rises with mtime == 20, falls after mtimecmp reset
    access(1'b1, 56'h0200_4000, 2'd3, 64'd20, rd, er, ir, sw);
    check("t2_cmp_store_err", {63'd0, er}, 64'd0);
    check("t2_irq_early",     {63'd0, ir}, 64'd0);
    for (int i = 0; i < 40 && !tm_irq; i++) tick();
    check("t2_irq_rise_timeout", {63'd0, tm_irq}, 64'd1);
    access(1'b0, 56'h0200_bff8, 2'd3, '0, rd, er, ir, sw);
    check("t2_mtime_at_rise", rd, 64'd20);
    check("t2_irq_held", {63'd0, tm_irq}, 64'd1);
    access(1'b1, 56'h0200_4000, 2'd3, 64'hffff_ffff_ffff_ffff, rd, er, ir, sw);
    check("t2_irq_fall", {63'd0, ir}, 64'd0);

    // 3: software interrupt via mipi
    access(1'b1, 56'h0200_0000, 2'd2, 64'h1, rd, er, ir, sw);
    check("t3_sw_set", {63'd0, sw}, 64'd1);
    check("t3_store_data_zero", rd, 64'd0);
    access(1'b0, 56'h0200_0000, 2'd3, '0, rd, er, ir, sw);
    check("t3_mipi_load", rd, 64'd1);
    access(1'b0, 56'h0200_0004, 2'd2, '0, rd, er, ir, sw);
    check("t3_mipi_off4_data", rd, 64'd0);
    check("t3_mipi_off4_err",  {63'd0, er}, 64'd0);
    access(1'b1, 56'h0200_0000, 2'd2, 64'h0, rd, er, ir, sw);
    check("t3_sw_clear", {63'd0, sw}, 64'd0);

    // 4: mtime wrap and half-word store (mtime values derived cycle by cycle)
    access(1'b1, 56'h0200_bff8, 2'd3, 64'hffff_ffff_ffff_fffe, rd, er, ir, sw);
    check("t4_store_err", {63'd0, er}, 64'd0);
    access(1'b0, 56'h0200_bff8, 2'd3, '0, rd, er, ir, sw);
    check("t4_all_ones", rd, 64'hffff_ffff_ffff_ffff);
    access(1'b0, 56'h0200_bff8, 2'd3, '0, rd, er, ir, sw);
    check("t4_wrapped", rd, 64'd1);
    access(1'b1, 56'h0200_bffc, 2'd2, 64'hdead_beef, rd, er, ir, sw);
    access(1'b0, 56'h0200_bff8, 2'd3, '0, rd, er, ir, sw);
    check("t4_upper_store", rd, 64'hdead_beef_0000_0005);
    access(1'b0, 56'h0200_bffc, 2'd2, '0, rd, er, ir, sw);
    check("t4_upper_load", rd, 64'h0000_0000_dead_beef);

    // 5: decode and size errors leave state untouched
    access(1'b0, 56'h0300_0000, 2'd3, '0, rd, er, ir, sw);
    check("t5_unmapped_err",  {63'd0, er}, 64'd1);
    check("t5_unmapped_data", rd, 64'd0);
    access(1'b1, 56'h0200_4004, 2'd3, 64'd0, rd, er, ir, sw);
    check("t5_misalign_err",  {63'd0, er}, 64'd1);
    access(1'b1, 56'h0200_0000, 2'd1, 64'd1, rd, er, ir, sw);
    check("t5_size1_err", {63'd0, er}, 64'd1);
    check("t5_size1_sw",  {63'd0, sw}, 64'd0);
    access(1'b0, 56'h01_0200_0000, 2'd3, '0, rd, er, ir, sw);
    check("t5_high_bits_err", {63'd0, er}, 64'd1);
    access(1'b0, 56'h0200_4000, 2'd3, '0, rd, er, ir, sw);
    check("t5_cmp_unchanged", rd, 64'hffff_ffff_ffff_ffff);
    check("t5_cmp_load_err",  {63'd0, er}, 64'd0);

    // 6: back-pressure on the response, then reset mid-response
    req_v = 1'b1; req_we = 1'b0; req_addr = 56'h0200_bff8; req_size = 2'd3;
    tick();
    req_v = 1'b0;
    held = resp_data;
    for (int i = 0; i < 5; i++) begin
      check("t6_resp_v_held", {63'd0, resp_v},    64'd1);
      check("t6_not_ready",   {63'd0, req_ready}, 64'd0);
      check("t6_data_stable", resp_data,          held);
      tick();
    end
    reset_n = 1'b0;
    tick();
    check("t6_rst_resp_v", {63'd0, resp_v},    64'd0);
    check("t6_rst_ready",  {63'd0, req_ready}, 64'd1);
    check("t6_rst_data",   resp_data,          64'd0);
    reset_n = 1'b1;
    access(1'b0, 56'h0200_4000, 2'd3, '0, rd, er, ir, sw);
    check("t6_cmp_after_rst", rd, 64'hffff_ffff_ffff_ffff);
    access(1'b0, 56'h0200_bff8, 2'd3, '0, rd, er, ir, sw);
    check("t6_mtime_after_rst", rd, 64'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
